// File: rtl/nexys_starship_spawn_sched.sv
// nexys_starship_spawn_sched: picks when and where monsters spawn for the four terminals and ramps difficulty
//   Clk, Reset_n        clock, asynchronous active-low reset
//   tick                one-cycle game-timer pulse that paces the spawn gap
//   play_flag/gameover  game running / game over
//   term_full[3:0]      [0]=top [1]=bottom [2]=left [3]=right, high = monster present
//   rand_val[7:0]       LFSR value, [1:0] selects the scan start terminal
//   spawn_req[3:0]      one-hot request held until acknowledged or timed out
//   spawn_idx[1:0]      current or last granted terminal
//   level[3:0]          difficulty level, saturating at 15
//   spawn_err           one-cycle pulse on acknowledge timeout
//   q_Idle..q_Halt      one-hot state flags
module nexys_starship_spawn_sched #(
  parameter logic [7:0] INIT_GAP         = 8'd6,
  parameter logic [7:0] MIN_GAP          = 8'd2,
  parameter logic [7:0] GAP_STEP         = 8'd1,
  parameter logic [7:0] SPAWNS_PER_LEVEL = 8'd4,
  parameter logic [7:0] ACK_TIMEOUT      = 8'd15,
  parameter int         MAX_ACTIVE       = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       play_flag,
  input  logic       gameover,
  input  logic [3:0] term_full,
  input  logic [7:0] rand_val,
  output logic [3:0] spawn_req,
  output logic [1:0] spawn_idx,
  output logic [3:0] level,
  output logic       spawn_err,
  output logic       q_Idle,
  output logic       q_Wait,
  output logic       q_Pick,
  output logic       q_Grant,
  output logic       q_Halt
);
  typedef enum logic [2:0] {IDLE, WAIT, PICK, GRANT, HALT} state_t;
  state_t state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d, cur_gap_q, cur_gap_d, spawn_cnt_q, spawn_cnt_d, ack_cnt_q, ack_cnt_d;
  logic [3:0] spawn_req_q, spawn_req_d, level_q, level_d;
  logic [1:0] spawn_idx_q, spawn_idx_d, tgt, cand;
  logic       spawn_err_q, spawn_err_d;
  logic [7:0] gap_dec;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      cur_gap_q   <= INIT_GAP;
      spawn_cnt_q <= '0;
      ack_cnt_q   <= '0;
      spawn_req_q <= '0;
      spawn_idx_q <= '0;
      level_q     <= '0;
      spawn_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      cur_gap_q   <= cur_gap_d;
      spawn_cnt_q <= spawn_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      spawn_req_q <= spawn_req_d;
      spawn_idx_q <= spawn_idx_d;
      level_q     <= level_d;
      spawn_err_q <= spawn_err_d;
    end
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    cur_gap_d   = cur_gap_q;
    spawn_cnt_d = spawn_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    spawn_req_d = spawn_req_q;
    spawn_idx_d = spawn_idx_q;
    level_d     = level_q;
    spawn_err_d = 1'b0;
    // scan downward so the last hit is the empty terminal closest after the random start
    tgt  = rand_val[1:0];
    cand = rand_val[1:0];
    for (int i = 3; i >= 0; i--) begin
      cand = rand_val[1:0] + 2'(i);
      if (!term_full[cand]) tgt = cand;
    end
    // compare in 9 bits so the floor test cannot wrap
    gap_dec = ({1'b0, cur_gap_q} >= {1'b0, MIN_GAP} + {1'b0, GAP_STEP}) ? cur_gap_q - GAP_STEP : MIN_GAP;
    if (gameover && state_q != IDLE) begin
      state_d     = HALT;
      spawn_req_d = '0;
    end else if (!play_flag && state_q != IDLE) begin
      // covers both an abort mid-game and the normal HALT exit; IDLE shows reset values
      state_d     = IDLE;
      spawn_req_d = '0;
      spawn_idx_d = '0;
      level_d     = '0;
    end else
      case (state_q)
        IDLE:
          if (play_flag) begin
            state_d     = WAIT;
            cur_gap_d   = INIT_GAP;
            gap_cnt_d   = INIT_GAP;
            level_d     = '0;
            spawn_cnt_d = '0;
          end
        WAIT:
          if (gap_cnt_q == '0) state_d = PICK;
          else if (tick) gap_cnt_d = gap_cnt_q - 8'd1;
        PICK:
          if ($countones(term_full) < MAX_ACTIVE && !(&term_full)) begin
            state_d     = GRANT;
            spawn_idx_d = tgt;
            spawn_req_d = 4'b0001 << tgt;
            ack_cnt_d   = '0;
          end
        GRANT:
          if (term_full[spawn_idx_q]) begin
            state_d     = WAIT;
            spawn_req_d = '0;
            if (spawn_cnt_q + 8'd1 == SPAWNS_PER_LEVEL) begin
              spawn_cnt_d = '0;
              level_d     = (level_q == 4'hF) ? level_q : level_q + 4'd1;
              cur_gap_d   = gap_dec;
              gap_cnt_d   = gap_dec;
            end else begin
              spawn_cnt_d = spawn_cnt_q + 8'd1;
              gap_cnt_d   = cur_gap_q;
            end
          end else if (ack_cnt_q == ACK_TIMEOUT - 8'd1) begin
            // ack_cnt counts from 0 on the request edge, so this is the ACK_TIMEOUT-th waiting cycle
            state_d     = WAIT;
            spawn_req_d = '0;
            spawn_err_d = 1'b1;
            gap_cnt_d   = cur_gap_q;
          end else ack_cnt_d = ack_cnt_q + 8'd1;
        default: ;
      endcase
  end
  assign spawn_req = spawn_req_q;
  assign spawn_idx = spawn_idx_q;
  assign level     = level_q;
  assign spawn_err = spawn_err_q;
  assign q_Idle    = state_q == IDLE;
  assign q_Wait    = state_q == WAIT;
  assign q_Pick    = state_q == PICK;
  assign q_Grant   = state_q == GRANT;
  assign q_Halt    = state_q == HALT;
endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// tb_nexys_starship_spawn_sched: directed self-checking bench for the spawn scheduler
module tb_nexys_starship_spawn_sched;
  logic       Clk, Reset_n, tick, play_flag, gameover;
  logic [3:0] term_full;
  logic [7:0] rand_val;
  logic [3:0] spawn_req, level, r4, l4;
  logic [1:0] spawn_idx, i4;
  logic       spawn_err, q_Idle, q_Wait, q_Pick, q_Grant, q_Halt;
  logic       e4, qi4, qw4, qp4, qg4, qh4;
  int errors = 0;
  int checks = 0;

  nexys_starship_spawn_sched dut (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .play_flag(play_flag), .gameover(gameover),
    .term_full(term_full), .rand_val(rand_val), .spawn_req(spawn_req), .spawn_idx(spawn_idx),
    .level(level), .spawn_err(spawn_err), .q_Idle(q_Idle), .q_Wait(q_Wait), .q_Pick(q_Pick),
    .q_Grant(q_Grant), .q_Halt(q_Halt));

  nexys_starship_spawn_sched #(.MAX_ACTIVE(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .tick(tick), .play_flag(play_flag), .gameover(gameover),
    .term_full(term_full), .rand_val(rand_val), .spawn_req(r4), .spawn_idx(i4),
    .level(l4), .spawn_err(e4), .q_Idle(qi4), .q_Wait(qw4), .q_Pick(qp4),
    .q_Grant(qg4), .q_Halt(qh4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    Reset_n = 1'b0; tick = 1'b0; play_flag = 1'b0; gameover = 1'b0; term_full = '0; rand_val = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic start_play();
    play_flag = 1'b1;
    @(negedge Clk);
  endtask

  // tick then one idle cycle per step, so the step count equals the gap; returns 99 if PICK never appears
  task automatic wait_gap(output int n);
    n = 99;
    for (int k = 1; k <= 30; k++) begin
      tick = 1'b1; @(negedge Clk);
      tick = 1'b0; @(negedge Clk);
      if (q_Pick) begin n = k; break; end
    end
  endtask

  task automatic grant_ack(input logic [3:0] oh);
    term_full = oh;
    @(negedge Clk);
    term_full = '0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; tick = 1'b0; play_flag = 1'b0; gameover = 1'b0; term_full = '0; rand_val = '0;
    repeat (2) @(negedge Clk);
    checks++; if (q_Idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", q_Idle); end
    checks++; if (spawn_req !== 4'h0) begin errors++; $display("FAIL reset_req: got %b expected 0000", spawn_req); end
    checks++; if (level !== 4'h0 || spawn_idx !== 2'd0 || spawn_err !== 1'b0) begin errors++; $display("FAIL reset_outs: got level=%0d idx=%0d err=%b expected 0 0 0", level, spawn_idx, spawn_err); end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (q_Idle !== 1'b1) begin errors++; $display("FAIL idle_no_play: got %b expected 1", q_Idle); end
  endtask

  task automatic test_latency();
    do_reset();
    rand_val = 8'h02;
    start_play();
    checks++; if (q_Wait !== 1'b1) begin errors++; $display("FAIL lat_wait: got %b expected 1", q_Wait); end
    for (int k = 0; k < 6; k++) begin
      tick = 1'b1; @(negedge Clk); tick = 1'b0;
    end
    checks++; if (q_Wait !== 1'b1 || spawn_req !== 4'h0) begin errors++; $display("FAIL lat_t0: got wait=%b req=%b expected 1 0000", q_Wait, spawn_req); end
    @(negedge Clk);
    checks++; if (q_Pick !== 1'b1 || spawn_req !== 4'h0) begin errors++; $display("FAIL lat_t1: got pick=%b req=%b expected 1 0000", q_Pick, spawn_req); end
    @(negedge Clk);
    checks++; if (spawn_req !== 4'b0100 || spawn_idx !== 2'd2) begin errors++; $display("FAIL lat_t2: got req=%b idx=%0d expected 0100 2", spawn_req, spawn_idx); end
    grant_ack(4'b0100);
    checks++; if (spawn_req !== 4'h0 || q_Wait !== 1'b1) begin errors++; $display("FAIL lat_ack: got req=%b wait=%b expected 0000 1", spawn_req, q_Wait); end
  endtask

  task automatic test_pick();
    int n;
    do_reset();
    rand_val = 8'h01;
    start_play();
    wait_gap(n);
    checks++; if (n != 6) begin errors++; $display("FAIL pick_gap: got %0d expected 6", n); end
    term_full = 4'b0110;
    @(negedge Clk);
    checks++; if (q_Pick !== 1'b1 || spawn_req !== 4'h0) begin errors++; $display("FAIL pick_max2_0110: got pick=%b req=%b expected 1 0000", q_Pick, spawn_req); end
    checks++; if (r4 !== 4'b1000 || i4 !== 2'd3) begin errors++; $display("FAIL pick_max4_0110: got req=%b idx=%0d expected 1000 3", r4, i4); end
    term_full = 4'b0011;
    repeat (2) @(negedge Clk);
    checks++; if (q_Pick !== 1'b1 || spawn_req !== 4'h0) begin errors++; $display("FAIL pick_max2_0011: got pick=%b req=%b expected 1 0000", q_Pick, spawn_req); end
    term_full = 4'b1000; rand_val = 8'h03;
    @(negedge Clk);
    checks++; if (spawn_req !== 4'b0001 || spawn_idx !== 2'd0) begin errors++; $display("FAIL pick_wrap: got req=%b idx=%0d expected 0001 0", spawn_req, spawn_idx); end
    play_flag = 1'b0; term_full = '0;
    @(negedge Clk);
    checks++; if (q_Idle !== 1'b1 || spawn_req !== 4'h0) begin errors++; $display("FAIL play_drop: got idle=%b req=%b expected 1 0000", q_Idle, spawn_req); end
  endtask

  task automatic test_ramp();
    int n, eg;
    logic [3:0] er;
    do_reset();
    start_play();
    for (int s = 1; s <= 20; s++) begin
      rand_val = 8'(s * 37);
      eg = (6 - (s - 1) / 4 > 2) ? 6 - (s - 1) / 4 : 2;
      wait_gap(n);
      checks++; if (n != eg) begin errors++; $display("FAIL ramp_gap s=%0d: got %0d expected %0d", s, n, eg); end
      @(negedge Clk);
      er = 4'b0001 << rand_val[1:0];
      checks++; if (spawn_req !== er) begin errors++; $display("FAIL ramp_req s=%0d: got %b expected %b", s, spawn_req, er); end
      grant_ack(er);
      if (s == 4) begin
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL ramp_level4: got %0d expected 1", level); end
      end
    end
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL ramp_level20: got %0d expected 5", level); end
    wait_gap(n);
    checks++; if (n != 2) begin errors++; $display("FAIL ramp_floor: got %0d expected 2", n); end
    @(negedge Clk);
    checks++; if (q_Grant !== 1'b1) begin errors++; $display("FAIL ramp_grant: got %b expected 1", q_Grant); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (spawn_req !== 4'h0 || level !== 4'd0 || q_Idle !== 1'b1) begin errors++; $display("FAIL async_reset: got req=%b level=%0d idle=%b expected 0000 0 1", spawn_req, level, q_Idle); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_timeout();
    int n, first, pulses;
    do_reset();
    rand_val = 8'h00;
    start_play();
    for (int s = 0; s < 3; s++) begin
      wait_gap(n); @(negedge Clk); grant_ack(4'b0001);
    end
    wait_gap(n);
    @(negedge Clk);
    checks++; if (spawn_req !== 4'b0001) begin errors++; $display("FAIL to_req: got %b expected 0001", spawn_req); end
    first = -1; pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (spawn_err) begin pulses++; if (first < 0) first = c; end
      if (c == 14) begin
        checks++; if (spawn_req !== 4'b0001) begin errors++; $display("FAIL to_hold: got %b expected 0001", spawn_req); end
      end
      if (c == 15) begin
        checks++; if (spawn_req !== 4'h0 || q_Wait !== 1'b1) begin errors++; $display("FAIL to_clear: got req=%b wait=%b expected 0000 1", spawn_req, q_Wait); end
      end
    end
    checks++; if (first != 15 || pulses != 1) begin errors++; $display("FAIL to_err: got first=%0d pulses=%0d expected 15 1", first, pulses); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL to_level: got %0d expected 0", level); end
    wait_gap(n);
    checks++; if (n != 6) begin errors++; $display("FAIL to_gap: got %0d expected 6", n); end
    @(negedge Clk);
    grant_ack(4'b0001);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL to_cnt: got level %0d expected 1", level); end
  endtask

  task automatic test_gameover();
    int n;
    do_reset();
    rand_val = 8'h02;
    start_play();
    for (int s = 0; s < 4; s++) begin
      wait_gap(n); @(negedge Clk); grant_ack(4'b0100);
    end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL go_level: got %0d expected 1", level); end
    tick = 1'b1; @(negedge Clk); tick = 1'b0;
    gameover = 1'b1;
    @(negedge Clk);
    checks++; if (q_Halt !== 1'b1 || spawn_req !== 4'h0 || level !== 4'd1) begin errors++; $display("FAIL go_halt: got halt=%b req=%b level=%0d expected 1 0000 1", q_Halt, spawn_req, level); end
    gameover = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (q_Halt !== 1'b1 || level !== 4'd1 || spawn_idx !== 2'd2) begin errors++; $display("FAIL go_frozen: got halt=%b level=%0d idx=%0d expected 1 1 2", q_Halt, level, spawn_idx); end
    play_flag = 1'b0;
    @(negedge Clk);
    checks++; if (q_Idle !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL go_idle: got idle=%b level=%0d expected 1 0", q_Idle, level); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_pick();
    test_ramp();
    test_timeout();
    test_gameover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
